// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg : shared encodings and default latencies for the MDU
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;

  localparam logic WSEL_LO = 1'b0;
  localparam logic WSEL_HI = 1'b1;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

endpackage

`default_nettype wire

// File: rtl/mdu_div_core.sv
// ---------------------------------------------------------------------------
// mdu_div_core : combinational signed/unsigned quotient and remainder
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam logic [WIDTH-1:0] C_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] C_ONES = {WIDTH{1'b1}};

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] b_safe;
  logic [WIDTH-1:0] mag_q;
  logic [WIDTH-1:0] mag_r;
  logic             neg_q;
  logic             neg_r;

  always_comb begin
    a_mag  = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag  = (is_signed && b[WIDTH-1]) ? -b : b;
    // Keep the divider defined when b is zero; that case is overridden below.
    b_safe = (b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    mag_q  = a_mag / b_safe;
    mag_r  = a_mag % b_safe;
    neg_q  = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
    neg_r  = is_signed && a[WIDTH-1];
    quot   = neg_q ? -mag_q : mag_q;
    rem    = neg_r ? -mag_r : mag_r;

    if (b == '0) begin
      quot = C_ONES;
      rem  = a;
    end else if (is_signed && (a == C_MIN) && (b == C_ONES)) begin
      quot = C_MIN;
      rem  = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mdu_hilo.sv
// ---------------------------------------------------------------------------
// mdu_hilo : fixed-latency multiply/divide unit with HI/LO registers
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mdu_hilo
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we,
  input  logic             wsel,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   pend_hi_q, pend_hi_d;
  logic [WIDTH-1:0]   pend_lo_q, pend_lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               launch;
  logic               commit;
  logic               mt_wr;

  logic               mul_signed;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  // Low 2*WIDTH bits of a sign-extended product equal the signed product.
  assign mul_signed = (op == MDU_MULT);
  assign a_ext      = {{WIDTH{mul_signed & a[WIDTH-1]}}, a};
  assign b_ext      = {{WIDTH{mul_signed & b[WIDTH-1]}}, b};
  assign prod       = a_ext * b_ext;

  mdu_div_core #(
    .WIDTH (WIDTH)
  ) u_div_core (
    .a         (a),
    .b         (b),
    .is_signed (op == MDU_DIV),
    .quot      (quot),
    .rem       (rem)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == S_RUN);
    launch = (state_q == S_IDLE) && start;
    commit = (state_q == S_RUN) && (cnt_q == '0);
    // start takes priority over an MTHI/MTLO on the same edge.
    mt_wr  = (state_q == S_IDLE) && !start && we;
  end

  always_comb begin
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (launch) begin
      if (op[1]) begin
        cnt_d     = DIV_LOAD;
        pend_hi_d = rem;
        pend_lo_d = quot;
      end else begin
        cnt_d     = MULT_LOAD;
        pend_hi_d = prod[2*WIDTH-1:WIDTH];
        pend_lo_d = prod[WIDTH-1:0];
      end
    end else if (busy && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    if (commit) begin
      hi_d = pend_hi_q;
      lo_d = pend_lo_q;
    end else if (mt_wr) begin
      if (wsel == WSEL_HI) hi_d = wdata;
      else                 lo_d = wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_hilo.sv
// ---------------------------------------------------------------------------
// tb_mdu_hilo : directed and randomized checks of mdu_hilo against a model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mdu_hilo;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        we;
  logic        wsel;
  logic [31:0] wdata;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_hi    = '0;
  logic [31:0] m_lo    = '0;

  mdu_hilo #(
    .WIDTH       (32),
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .we    (we),
    .wsel  (wsel),
    .wdata (wdata),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Architectural result straight from the MIPS definitions, using 64-bit math.
  task automatic ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] rh, output logic [31:0] rl);
    longint      sx;
    longint      sy;
    longint      q;
    longint      r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rh = '0;
    rl = '0;
    case (o)
      2'd0: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
      2'd1: begin p = {32'd0, x} * {32'd0, y}; rh = p[63:32]; rl = p[31:0]; end
      default: begin
        if (y == 32'd0) begin
          rh = x;
          rl = 32'hFFFF_FFFF;
        end else if (o == 2'd2) begin
          q  = sx / sy;
          r  = sx % sy;
          rl = q[31:0];
          rh = r[31:0];
        end else begin
          rl = x / y;
          rh = x % y;
        end
      end
    endcase
  endtask

  // mode: 0 plain, 1 extra start while busy, 2 we pulses while busy, 3 we with start
  task automatic run_op(input logic [1:0] op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                        input int mode);
    logic [31:0] eh;
    logic [31:0] el;
    int          n;
    int          exp_n;
    ref_model(op_v, a_v, b_v, eh, el);
    exp_n = (op_v < 2'd2) ? 5 : 10;
    op    = op_v;
    a     = a_v;
    b     = b_v;
    start = 1'b1;
    if (mode == 3) begin
      we    = 1'b1;
      wsel  = 1'b1;
      wdata = 32'h0000_BEEF;
    end
    @(posedge clk); #1;
    start = 1'b0;
    we    = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    if (mode == 3) check("we_dropped_hi", hi, m_hi);
    n = 0;
    while (busy && n < 100) begin
      if (n == 1 && mode == 1) begin
        start = 1'b1;
        op    = 2'($urandom_range(0, 3));
        a     = $urandom;
        b     = $urandom;
      end
      if (n == 1 && mode == 2) begin we = 1'b1; wsel = 1'b0; wdata = 32'hDEAD; end
      if (n == 2 && mode == 2) begin we = 1'b1; wsel = 1'b1; wdata = 32'hDEAD; end
      @(posedge clk); #1;
      start = 1'b0;
      we    = 1'b0;
      n++;
      if (busy) begin
        check("hold_hi", hi, m_hi);
        check("hold_lo", lo, m_lo);
      end
    end
    check("busy_len", 32'(n), 32'(exp_n));
    m_hi = eh;
    m_lo = el;
    check("res_hi", hi, m_hi);
    check("res_lo", lo, m_lo);
  endtask

  task automatic mt_write(input logic sel, input logic [31:0] d);
    we    = 1'b1;
    wsel  = sel;
    wdata = d;
    @(posedge clk); #1;
    we = 1'b0;
    if (sel) m_hi = d;
    else     m_lo = d;
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    start = 1'b0;
    op    = '0;
    a     = '0;
    b     = '0;
    we    = 1'b0;
    wsel  = 1'b0;
    wdata = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    #10 reset = 1'b1;
    @(posedge clk); #1;

    run_op(2'd0, 32'hFFFF_FFFE, 32'd3, 0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(2'd3, 32'd7, 32'd0, 0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(2'd2, 32'h0000_0005, 32'd0, 0);
    mt_write(1'b0, 32'h1234);
    mt_write(1'b1, 32'h5678);
    run_op(2'd0, 32'd2, 32'd3, 2);
    run_op(2'd2, 32'd100, 32'hFFFF_FFF9, 1);
    run_op(2'd1, 32'd4, 32'd5, 3);

    // Asynchronous reset in the middle of a MULT.
    op    = 2'd0;
    a     = 32'd9;
    b     = 32'd9;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    m_hi = '0;
    m_lo = '0;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    #3 reset = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_hi", hi, 32'd0);
    check("post_rst_lo", lo, 32'd0);

    for (int i = 0; i < 40; i++) begin
      int          sel;
      logic [31:0] ra;
      logic [31:0] rb;
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        mt_write(1'($urandom_range(0, 1)), $urandom);
      end else begin
        ra = $urandom;
        rb = $urandom;
        case ($urandom_range(0, 7))
          0: ra = 32'h8000_0000;
          1: ra = 32'd0;
          default: ;
        endcase
        case ($urandom_range(0, 7))
          0: rb = 32'd0;
          1: rb = 32'hFFFF_FFFF;
          2: rb = 32'($urandom_range(1, 9));
          default: ;
        endcase
        run_op(2'($urandom_range(0, 3)), ra, rb, 0);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit with HI/LO registers for the P6 pipelined MIPS core.
- Sits beside the ALU in the EX stage and consumes operands forwarded into EX.
- Executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency, and services MTHI/MTLO writes and MFHI/MFLO reads.
- Exports busy so the hazard unit stalls any dependent MD instruction in D.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be >= 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  launch the operation in op; sampled on the rising edge.
- op  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- a  input  WIDTH  rs operand.
- b  input  WIDTH  rt operand.
- we  input  1  MTHI/MTLO write strobe.
- wsel  input  1  0=LO, 1=HI (for we).
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in flight.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous assert, synchronous-release behaviour on the next edge): hi=0, lo=0, busy=0, counter=0, pending result cleared. Reset mid-operation aborts it; HI/LO stay 0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, down-counter active.
- IDLE→RUN on an edge with start=1:
  - Full result is computed from a/b/op at that edge and latched into pending_hi/pending_lo.
  - Counter loads MULT_CYCLES-1 (op 0/1) or DIV_CYCLES-1 (op 2/3).
- RUN:
  - Counter decrements each edge.
  - On the edge where counter==0: hi<=pending_hi, lo<=pending_lo, busy<=0, return to IDLE.
  - busy is therefore high for exactly N cycles after the start edge.
  - New HI/LO values are visible in the cycle busy first reads 0.
- busy is a pure register output. The hazard unit stalls on (start | busy); start is not combinationally folded into busy.
- Arithmetic:
  - MULT: signed 32x32→64, {hi,lo} = product.
  - MULTU: unsigned 32x32→64, {hi,lo} = product.
  - DIV: signed; lo = quotient truncated toward zero, hi = remainder with the sign of a.
  - DIVU: unsigned; lo = quotient, hi = remainder.
- Divide by zero (b=0): lo=32'hFFFF_FFFF, hi=a, for both signed and unsigned.
- Signed overflow (a=32'h8000_0000, b=-1): lo=32'h8000_0000, hi=0.
- start while busy: ignored. The in-flight op is unaffected and the counter is not reloaded.
- we in IDLE with start=0: the selected register takes wdata on that edge.
- we while busy=1: ignored. The pipeline guarantees this cannot occur; the RTL still must not corrupt HI/LO.
- start and we on the same edge: start wins, we is dropped.
- hi/lo are register outputs. MFHI/MFLO read them directly and the pipeline stalls while busy.
- No flush input. A started operation always completes unless reset is asserted.

Decomposition:
- Package mdu_pkg:
  - op encodings MDU_MULT/MDU_MULTU/MDU_DIV/MDU_DIVU.
  - WSEL_LO/WSEL_HI.
  - default cycle constants.
- Sub-module mdu_div_core: combinational signed/unsigned quotient/remainder including the divide-by-zero and overflow cases; instantiated once.
- Multiplication stays inline.

Test Plan:
- Reset low, then high; MULT a=32'hFFFF_FFFE (-2), b=3 → busy high exactly 5 cycles; then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA.
- MULTU a=32'hFFFF_FFFF, b=32'hFFFF_FFFF → after 5 cycles hi=32'hFFFF_FFFE, lo=32'h0000_0001.
- DIV a=-7, b=2 → busy 10 cycles; lo=32'hFFFF_FFFD (-3), hi=32'hFFFF_FFFF (-1). DIVU a=7, b=0 → lo=32'hFFFF_FFFF, hi=7. DIV a=32'h8000_0000, b=-1 → lo=32'h8000_0000, hi=0.
- MTLO 32'h1234 with we=1, wsel=0 in IDLE → lo=32'h1234 next cycle. Then MULT 2x3 with a we=1 pulse (wdata=32'hDEAD) during busy → final lo=6, hi=0, no DEAD value.
- start=1 again at cycle 2 of a DIV in flight, with different operands → ignored; busy still drops at cycle 10 with the first DIV's result. start plus we on the same edge in IDLE → op starts, we dropped.
- Assert reset at cycle 3 of a MULT → busy=0, hi=lo=0 immediately (asynchronous). After release, no stale write occurs.
